// File: rtl/alu_top.sv
// Four-unit registered ALU (arithmetic, logic, compare, shift) with per-unit result and activity flag.
// Optional divider on arithmetic op 11 is built only when ALU_DIV_EN is defined.
module alu_top #(
  parameter int Operand_SIZE = 16,
  parameter int ALU_OUT      = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [Operand_SIZE-1:0] A,
  input  logic [Operand_SIZE-1:0] B,
  input  logic [3:0]              ALU_FUN,
  output logic [ALU_OUT-1:0]      Arith_out,
  output logic                    Carry_OUT,
  output logic                    Arith_Flag,
  output logic [ALU_OUT-1:0]      Logic_OUT,
  output logic                    Logic_Flag,
  output logic [ALU_OUT-1:0]      CMP_OUT,
  output logic                    CMP_Flag,
  output logic [ALU_OUT-1:0]      SHIFT_OUT,
  output logic                    SHIFT_Flag
);

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

  unit_e              unit;
  logic [1:0]         op;
  logic [ALU_OUT-1:0] a_ext;
  logic [ALU_OUT-1:0] b_ext;
  logic [ALU_OUT-1:0] sum;
  logic [ALU_OUT-1:0] arith_res;
  logic               carry_res;
  logic [ALU_OUT-1:0] logic_res;
  logic [ALU_OUT-1:0] cmp_res;
  logic [ALU_OUT-1:0] shift_res;

  assign unit  = unit_e'(ALU_FUN[3:2]);
  assign op    = ALU_FUN[1:0];
  assign a_ext = ALU_OUT'(A);
  assign b_ext = ALU_OUT'(B);
  assign sum   = a_ext + b_ext;

  always_comb begin
    arith_res = '0;
    carry_res = 1'b0;
    case (op)
      2'b00: begin
        arith_res = sum;
        carry_res = sum[Operand_SIZE];
      end
      2'b01: begin
        arith_res = a_ext - b_ext;
        carry_res = (A < B);
      end
      2'b10: arith_res = a_ext * b_ext;
      default: begin
`ifdef ALU_DIV_EN
        arith_res = (b_ext == '0) ? '0 : (a_ext / b_ext);
`else
        arith_res = '0;
`endif
      end
    endcase
  end

  // NAND/NOR invert the zero-extended operands, so upper bits come out set
  always_comb begin
    logic_res = '0;
    case (op)
      2'b00:   logic_res = a_ext & b_ext;
      2'b01:   logic_res = a_ext | b_ext;
      2'b10:   logic_res = ~(a_ext & b_ext);
      default: logic_res = ~(a_ext | b_ext);
    endcase
  end

  always_comb begin
    cmp_res = '0;
    case (op)
      2'b01:   cmp_res = (A == B) ? ALU_OUT'(1) : '0;
      2'b10:   cmp_res = (A > B)  ? ALU_OUT'(2) : '0;
      2'b11:   cmp_res = (A < B)  ? ALU_OUT'(3) : '0;
      default: cmp_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (op)
      2'b00:   shift_res = a_ext >> 1;
      2'b01:   shift_res = a_ext << 1;
      2'b10:   shift_res = b_ext >> 1;
      default: shift_res = b_ext << 1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Arith_out  <= '0;
      Carry_OUT  <= 1'b0;
      Arith_Flag <= 1'b0;
      Logic_OUT  <= '0;
      Logic_Flag <= 1'b0;
      CMP_OUT    <= '0;
      CMP_Flag   <= 1'b0;
      SHIFT_OUT  <= '0;
      SHIFT_Flag <= 1'b0;
    end else begin
      Arith_out  <= (unit == UNIT_ARITH) ? arith_res : '0;
      Carry_OUT  <= (unit == UNIT_ARITH) && carry_res;
      Arith_Flag <= (unit == UNIT_ARITH);
      Logic_OUT  <= (unit == UNIT_LOGIC) ? logic_res : '0;
      Logic_Flag <= (unit == UNIT_LOGIC);
      CMP_OUT    <= (unit == UNIT_CMP) ? cmp_res : '0;
      CMP_Flag   <= (unit == UNIT_CMP);
      SHIFT_OUT  <= (unit == UNIT_SHIFT) ? shift_res : '0;
      SHIFT_Flag <= (unit == UNIT_SHIFT);
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed cases from the ALU function table plus randomized
// operations, each compared to an arithmetic reference model after the registering edge.
module tb_alu_top;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [31:0] Arith_out;
  logic        Carry_OUT;
  logic        Arith_Flag;
  logic [31:0] Logic_OUT;
  logic        Logic_Flag;
  logic [31:0] CMP_OUT;
  logic        CMP_Flag;
  logic [31:0] SHIFT_OUT;
  logic        SHIFT_Flag;

  int errors = 0;
  int checks = 0;

  alu_top #(.Operand_SIZE(16), .ALU_OUT(32)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_out(Arith_out), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .SHIFT_OUT(SHIFT_OUT), .SHIFT_Flag(SHIFT_Flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  task automatic run_op(input logic rst, input int unsigned fun, input int unsigned a,
                        input int unsigned b);
    longint unsigned ar, lr, cr, sr;
    bit ac, af, lf, cf, sf;
    int unsigned unit, op;
    ar = 0; lr = 0; cr = 0; sr = 0;
    ac = 0; af = 0; lf = 0; cf = 0; sf = 0;
    unit = fun / 4;
    op   = fun % 4;
    if (!rst) begin
      case (unit)
        0: begin
          af = 1;
          case (op)
            0: begin ar = a + b; ac = (a + b) >= 65536; end
            1: begin ar = (longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000; ac = a < b; end
            2: ar = longint'(a) * longint'(b);
            default: begin
`ifdef ALU_DIV_EN
              ar = (b == 0) ? 0 : a / b;
`else
              ar = 0;
`endif
            end
          endcase
        end
        1: begin
          lf = 1;
          case (op)
            0: lr = a & b;
            1: lr = a | b;
            2: lr = 64'hFFFF_FFFF - (a & b);
            default: lr = 64'hFFFF_FFFF - (a | b);
          endcase
        end
        2: begin
          cf = 1;
          case (op)
            1: cr = (a == b) ? 1 : 0;
            2: cr = (a > b) ? 2 : 0;
            3: cr = (a < b) ? 3 : 0;
            default: cr = 0;
          endcase
        end
        default: begin
          sf = 1;
          case (op)
            0: sr = a / 2;
            1: sr = a * 2;
            2: sr = b / 2;
            default: sr = b * 2;
          endcase
        end
      endcase
    end
    @(negedge CLK);
    RST = rst;
    ALU_FUN = 4'(fun);
    A = 16'(a);
    B = 16'(b);
    @(posedge CLK);
    #1;
    check("arith_out", Arith_out, 32'(ar));
    check("carry", 32'(Carry_OUT), 32'(ac));
    check("arith_flag", 32'(Arith_Flag), 32'(af));
    check("logic_out", Logic_OUT, 32'(lr));
    check("logic_flag", 32'(Logic_Flag), 32'(lf));
    check("cmp_out", CMP_OUT, 32'(cr));
    check("cmp_flag", 32'(CMP_Flag), 32'(cf));
    check("shift_out", SHIFT_OUT, 32'(sr));
    check("shift_flag", 32'(SHIFT_Flag), 32'(sf));
  endtask

  initial begin
    int unsigned ra, rb;
    RST = 1'b1;
    A = '0;
    B = '0;
    ALU_FUN = '0;

    // Reset state with an arbitrary function pending
    run_op(1'b1, 4'b0010, 128, 8);

    // Directed function table, A=128 B=8
    for (int unsigned f = 0; f < 16; f++) run_op(1'b0, f, 128, 8);

    // Literal spot checks on the table values
    run_op(1'b0, 4'b0110, 128, 8);
    check("nand_lit", Logic_OUT, 32'hFFFF_FFFF);
    run_op(1'b0, 4'b0111, 128, 8);
    check("nor_lit", Logic_OUT, 32'hFFFF_FF77);
    run_op(1'b0, 4'b0010, 128, 8);
    check("mul_lit", Arith_out, 32'd1024);

    // Compare and arithmetic boundaries
    run_op(1'b0, 4'b1001, 5, 5);
    check("eq_lit", CMP_OUT, 32'd1);
    run_op(1'b0, 4'b1011, 3, 9);
    check("lt_lit", CMP_OUT, 32'd3);
    run_op(1'b0, 4'b0000, 16'hFFFF, 1);
    check("add_carry_lit", Arith_out, 32'h0001_0000);
    run_op(1'b0, 4'b0001, 1, 2);
    check("sub_borrow_lit", Arith_out, 32'hFFFF_FFFF);
    run_op(1'b0, 4'b0011, 7, 0);
    run_op(1'b0, 4'b0010, 16'hFFFF, 16'hFFFF);
    run_op(1'b0, 4'b1101, 16'hFFFF, 0);
    run_op(1'b0, 4'b1111, 0, 16'h8001);

    // Two-edge reset during an operation, then recovery
    run_op(1'b0, 4'b0000, 300, 400);
    run_op(1'b1, 4'b0000, 300, 400);
    run_op(1'b1, 4'b0101, 300, 400);
    run_op(1'b0, 4'b0101, 300, 400);

    // Randomized operations with occasional reset
    for (int i = 0; i < 300; i++) begin
      ra = $urandom_range(0, 65535);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = $urandom_range(0, 3);
        default: rb = $urandom_range(0, 65535);
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 15);
      run_op(($urandom_range(0, 19) == 0), $urandom_range(0, 15), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_top.md
# alu_top

16-bit four-unit ALU with registered outputs: a function decoder drives one of four units (arithmetic, logic, compare, shift) on every clock. Each unit has its own 32-bit registered result and an activity flag. The block is the top-level datapath integration of the ALU hierarchy. It is clocked by a single clock and cleared by a synchronous reset.

## Interface
- Operand_SIZE, 16, operand width of A and B
- ALU_OUT, 32, width of every unit result bus
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- A  input  Operand_SIZE  operand A (unsigned)
- B  input  Operand_SIZE  operand B (unsigned)
- ALU_FUN  input  4  function select; [3:2] picks unit, [1:0] picks operation
- Arith_out  output  ALU_OUT  arithmetic result
- Carry_OUT  output  1  carry (add) / borrow (sub)
- Arith_Flag  output  1  arithmetic unit active
- Logic_OUT  output  ALU_OUT  logic result
- Logic_Flag  output  1  logic unit active
- CMP_OUT  output  ALU_OUT  compare result
- CMP_Flag  output  1  compare unit active
- SHIFT_OUT  output  ALU_OUT  shift result
- SHIFT_Flag  output  1  shift unit active

## Operation
- Decoder: ALU_FUN[3:2] = 00 arith, 01 logic, 10 compare, 11 shift; exactly one unit enabled per cycle.
- Selected unit registers its result and raises its flag; every non-selected unit registers result 0 and flag 0.
- Operands are zero-extended to ALU_OUT before operating.
- Arith [1:0]: 00 A+B, Carry_OUT = sum bit 16; 01 A−B mod 2^32, Carry_OUT = 1 when A<B; 10 A*B (full 32-bit product), Carry_OUT=0; 11 A/B integer quotient, B=0 gives 0, Carry_OUT=0.
- Logic [1:0]: 00 A&B; 01 A|B; 10 ~(A&B); 11 ~(A|B); inversion over full 32 bits (A=128,B=8 → NAND 0xFFFFFFFF, NOR 0xFFFFFF77).
- Compare [1:0]: 00 NOP → 0; 01 → 1 if A==B else 0; 10 → 2 if A>B else 0; 11 → 3 if A<B else 0.
- Shift [1:0]: 00 A>>1; 01 A<<1; 10 B>>1; 11 B<<1; logical, into 32-bit field (no bits lost on left shift).
- Carry_OUT is 0 whenever arithmetic unit is not selected.

## Timing
- Latency: one clock; inputs sampled at rising edge N appear on outputs after edge N, stable until edge N+1.
- Outputs are pure registers; no combinational path from inputs to outputs.
- Reset: RST high at a rising edge forces all results, Carry_OUT and all flags to 0 on that edge, overriding any ALU_FUN; first valid result appears one cycle after RST falls.
- Reset mid-operation: in-flight result discarded; no state beyond output registers.
- ALU_FUN change between edges: only the value at the edge matters.

## Configuration
- ALU_DIV_EN: when defined, arithmetic op 11 performs A/B as specified. When undefined, the divider is not built; op 11 yields Arith_out=0, Carry_OUT=0, Arith_Flag=1.

## Test plan
- A=128, B=8, RST=0, ALU_FUN=0000/0001/0010/0011 → Arith_out 136/120/1024/16, Arith_Flag=1, other flags 0 (16 only with ALU_DIV_EN; else 0).
- Same operands, ALU_FUN=0100/0101/0110/0111 → Logic_OUT 0/136/0xFFFFFFFF/0xFFFFFF77, Logic_Flag=1, Arith_out=0.
- ALU_FUN=1000/1001/1010/1011 → CMP_OUT 0/0/2/0; repeat with A=B=5 on 1001 → 1, with A=3,B=9 on 1011 → 3.
- ALU_FUN=1100/1101/1110/1111 → SHIFT_OUT 64/256/4/16, SHIFT_Flag=1.
- A=0xFFFF, B=1, 0000 → Arith_out 0x10000, Carry_OUT=1; A=1,B=2, 0001 → Arith_out 0xFFFFFFFF, Carry_OUT=1; A=7,B=0, 0011 → 0.
- Assert RST=1 for two edges during any operation → all outputs and flags 0 after first edge; deassert → correct result one edge later.
